qam16_rx_monitor: RTL and testbench

Receive-side companion to `channel_top`: hard-decision 16-QAM slicer/demapper with an in-line error monitor. It consumes the noisy `rx_I`/`rx_Q` stream from the AWGN channel and emits Gray-coded 4-bit symbols. It aligns the received symbols against a buffered copy of the transmitted reference stream and accumulates symbol and bit errors over a programmable measurement window. This is the on-chip BER meter for the noise-magnitude sweep.

---
 rtl/gdsp_pkg.sv | 31 +++
 rtl/sym_fifo.sv | 67 ++++++
 rtl/qam16_rx_monitor.sv | 147 ++++++++++++++
 tb/tb_qam16_rx_monitor.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gdsp_pkg.sv
// Shared DSP types and helpers: sample format, 16-QAM slicer and rx monitor state.
package gdsp_pkg;

    localparam int unsigned SAMPLE_W = 12;
    localparam int QAM_THR = 1296;

    typedef logic signed [SAMPLE_W-1:0] sample_t;
    typedef logic [3:0] qam_sym_t;

    typedef enum logic [1:0] {
        RXMON_IDLE    = 2'd0,
        RXMON_MEASURE = 2'd1,
        RXMON_HOLD    = 2'd2
    } rxmon_state_t;

    // Hard decision on one axis; Gray code +3:10, +1:11, -1:01, -3:00.
    function automatic logic [1:0] qam16_slice(input sample_t v);
        logic [1:0] code;
        if (v >= sample_t'(QAM_THR)) begin
            code = 2'b10;
        end else if (v >= sample_t'(0)) begin
            code = 2'b11;
        end else if (v >= sample_t'(-QAM_THR)) begin
            code = 2'b01;
        end else begin
            code = 2'b00;
        end
        return code;
    endfunction

endpackage

// File: rtl/sym_fifo.sv
// Synchronous symbol FIFO; head word is read combinationally, full/empty are registered.
module sym_fifo #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] head_c,
    output logic             full,
    output logic             empty
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic [AW:0]      count_next;
    logic             wr_en;
    logic             rd_en;

    // A push into a full FIFO is accepted only when a pop frees a slot in the same cycle.
    assign wr_en  = push & (~full | pop);
    assign rd_en  = pop & ~empty;
    assign head_c = mem[rd_ptr];

    always_comb begin
        count_next = count;
        if (wr_en && !rd_en) begin
            count_next = count + (AW+1)'(1);
        end else if (rd_en && !wr_en) begin
            count_next = count - (AW+1)'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (rd_en) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count <= count_next;
            full  <= (count_next == DEPTH_C);
            empty <= (count_next == '0);
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= din;
        end
    end

endmodule

// File: rtl/qam16_rx_monitor.sv
// 16-QAM hard slicer/demapper with reference alignment FIFO and windowed symbol/bit error counters.
module qam16_rx_monitor
    import gdsp_pkg::*;
#(
    parameter int unsigned REF_DEPTH = 16,
    parameter int unsigned WIN_LEN   = 1024,
    parameter int unsigned CNT_W     = 20
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  sample_t          rx_I,
    input  sample_t          rx_Q,
    input  logic             rx_valid,
    input  sample_t          ref_I,
    input  sample_t          ref_Q,
    input  logic             ref_valid,
    input  logic             start,
    output qam_sym_t         sym_out,
    output logic             sym_valid,
    output logic [CNT_W-1:0] sym_err_cnt,
    output logic [CNT_W-1:0] bit_err_cnt,
    output logic [15:0]      cmp_cnt,
    output logic             busy,
    output logic             win_done,
    output logic             ref_ovf,
    output logic             ref_unf
);

    localparam logic [CNT_W-1:0]   CNT_MAX   = '1;
    localparam logic [CNT_W+2:0]   CNT_MAX_X = {3'b000, CNT_MAX};
    localparam logic [15:0]        WIN_LEN_C = 16'(WIN_LEN);

    rxmon_state_t     state;
    qam_sym_t         ref_sym;
    qam_sym_t         ref_head;
    qam_sym_t         diff;
    logic             push;
    logic             pop;
    logic             fifo_full;
    logic             fifo_empty;
    logic             cmp_ok;
    logic             ovf_ev;
    logic             unf_ev;
    logic             flag_clr;
    logic [2:0]       bit_inc;
    logic [CNT_W+2:0] bit_sum;
    logic [CNT_W-1:0] bit_next;
    logic [CNT_W-1:0] sym_next;
    logic [15:0]      cmp_next;

    assign ref_sym = {qam16_slice(ref_I), qam16_slice(ref_Q)};
    assign push    = ref_valid & en;
    assign pop     = sym_valid & en;

    sym_fifo #(
        .DEPTH(REF_DEPTH),
        .WIDTH(4)
    ) u_ref_fifo (
        .clk    (clk),
        .rst    (rst),
        .push   (push),
        .pop    (pop),
        .din    (ref_sym),
        .head_c (ref_head),
        .full   (fifo_full),
        .empty  (fifo_empty)
    );

    // A simultaneous pop keeps a full FIFO from overflowing; a pop on empty never compares.
    assign cmp_ok   = pop & ~fifo_empty;
    assign unf_ev   = pop & fifo_empty;
    assign ovf_ev   = push & fifo_full & ~sym_valid;
    assign flag_clr = start & (state == RXMON_IDLE);

    always_comb begin
        diff     = sym_out ^ ref_head;
        bit_inc  = 3'(diff[0]) + 3'(diff[1]) + 3'(diff[2]) + 3'(diff[3]);
        bit_sum  = {3'b000, bit_err_cnt} + (CNT_W+3)'(bit_inc);
        bit_next = (bit_sum > CNT_MAX_X) ? CNT_MAX : bit_sum[CNT_W-1:0];
        sym_next = (sym_err_cnt == CNT_MAX) ? sym_err_cnt : sym_err_cnt + CNT_W'(1);
        cmp_next = cmp_cnt + 16'd1;
    end

    // Slicer stage.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sym_valid <= 1'b0;
            sym_out   <= '0;
        end else if (en) begin
            sym_valid <= rx_valid;
            if (rx_valid) begin
                sym_out <= {qam16_slice(rx_I), qam16_slice(rx_Q)};
            end
        end
    end

    // Window FSM, counters and sticky flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= RXMON_IDLE;
            busy        <= 1'b0;
            win_done    <= 1'b0;
            sym_err_cnt <= '0;
            bit_err_cnt <= '0;
            cmp_cnt     <= '0;
            ref_ovf     <= 1'b0;
            ref_unf     <= 1'b0;
        end else if (en) begin
            win_done <= 1'b0;
            ref_ovf  <= (ref_ovf & ~flag_clr) | ovf_ev;
            ref_unf  <= (ref_unf & ~flag_clr) | unf_ev;
            if (start) begin
                sym_err_cnt <= '0;
                bit_err_cnt <= '0;
                cmp_cnt     <= '0;
                state       <= RXMON_MEASURE;
                busy        <= 1'b1;
            end else begin
                case (state)
                    RXMON_MEASURE: begin
                        if (cmp_ok) begin
                            cmp_cnt <= cmp_next;
                            if (diff != '0) begin
                                sym_err_cnt <= sym_next;
                            end
                            bit_err_cnt <= bit_next;
                            if (cmp_next == WIN_LEN_C) begin
                                state    <= RXMON_HOLD;
                                busy     <= 1'b0;
                                win_done <= 1'b1;
                            end
                        end
                    end
                    RXMON_IDLE, RXMON_HOLD: begin
                        busy <= 1'b0;
                    end
                    default: begin
                        state <= RXMON_IDLE;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_qam16_rx_monitor.sv
// Randomized and directed bench for qam16_rx_monitor against a queue-based behavioural model.
module tb_qam16_rx_monitor;
    import gdsp_pkg::*;

    localparam int REF_DEPTH = 16;
    localparam int WIN_LEN   = 1024;
    localparam int CNT_W     = 20;
    localparam int CNT_W2    = 4;

    typedef logic [3:0] sym4_t;

    logic    clk = 1'b0;
    logic    rst, en, rx_valid, ref_valid, start;
    sample_t rx_I, rx_Q, ref_I, ref_Q;

    qam_sym_t          a_sym_out, b_sym_out;
    logic              a_sym_valid, b_sym_valid;
    logic [CNT_W-1:0]  a_sym_err, a_bit_err;
    logic [CNT_W2-1:0] b_sym_err, b_bit_err;
    logic [15:0]       a_cmp, b_cmp;
    logic              a_busy, b_busy, a_win_done, b_win_done;
    logic              a_ovf, b_ovf, a_unf, b_unf;

    always #5 clk = ~clk;

    qam16_rx_monitor #(.REF_DEPTH(REF_DEPTH), .WIN_LEN(WIN_LEN), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .en(en), .rx_I(rx_I), .rx_Q(rx_Q), .rx_valid(rx_valid),
        .ref_I(ref_I), .ref_Q(ref_Q), .ref_valid(ref_valid), .start(start),
        .sym_out(a_sym_out), .sym_valid(a_sym_valid), .sym_err_cnt(a_sym_err),
        .bit_err_cnt(a_bit_err), .cmp_cnt(a_cmp), .busy(a_busy), .win_done(a_win_done),
        .ref_ovf(a_ovf), .ref_unf(a_unf));

    qam16_rx_monitor #(.REF_DEPTH(REF_DEPTH), .WIN_LEN(WIN_LEN), .CNT_W(CNT_W2)) dut_sat (
        .clk(clk), .rst(rst), .en(en), .rx_I(rx_I), .rx_Q(rx_Q), .rx_valid(rx_valid),
        .ref_I(ref_I), .ref_Q(ref_Q), .ref_valid(ref_valid), .start(start),
        .sym_out(b_sym_out), .sym_valid(b_sym_valid), .sym_err_cnt(b_sym_err),
        .bit_err_cnt(b_bit_err), .cmp_cnt(b_cmp), .busy(b_busy), .win_done(b_win_done),
        .ref_ovf(b_ovf), .ref_unf(b_unf));

    // Behavioural model state: unsaturated counts, window phase, FIFO as a queue.
    sym4_t q[$];
    bit    m_sv, m_meas, m_hold, m_done, m_ovf, m_unf;
    sym4_t m_so;
    int    m_sym, m_bit, m_cmp;
    int    errors = 0;
    int    checks = 0;

    function automatic logic [1:0] ref_code(input int v);
        if (v >= 1296) return 2'b10;
        if (v >= 0) return 2'b11;
        if (v >= -1296) return 2'b01;
        return 2'b00;
    endfunction

    function automatic int amp(input logic [1:0] c);
        case (c)
            2'b10:   return 1944;
            2'b11:   return 648;
            2'b01:   return -648;
            default: return -1944;
        endcase
    endfunction

    function automatic sample_t noisy(input int a);
        int v;
        v = a + int'($urandom_range(0, 1000)) - 500;
        if (v > 2047) v = 2047;
        if (v < -2048) v = -2048;
        return sample_t'(v);
    endfunction

    function automatic int sat(input int v, input int w);
        int mx;
        mx = (1 << w) - 1;
        return (v > mx) ? mx : v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_step();
        bit    pop, emp, full, cmp, clr_flags;
        sym4_t head;
        int    nbits;
        if (rst) begin
            q.delete();
            m_sv = 0; m_so = '0; m_meas = 0; m_hold = 0; m_done = 0;
            m_ovf = 0; m_unf = 0; m_sym = 0; m_bit = 0; m_cmp = 0;
            return;
        end
        if (!en) return;
        pop  = m_sv;
        emp  = (q.size() == 0);
        full = (q.size() == REF_DEPTH);
        cmp  = pop && !emp;
        head = emp ? 4'h0 : q[0];
        clr_flags = start && !m_meas && !m_hold;
        m_ovf = (clr_flags ? 1'b0 : m_ovf) | (ref_valid && full && !pop);
        m_unf = (clr_flags ? 1'b0 : m_unf) | (pop && emp);
        if (cmp) void'(q.pop_front());
        if (ref_valid && !(full && !pop)) q.push_back({ref_code(int'(ref_I)), ref_code(int'(ref_Q))});
        m_done = 0;
        if (start) begin
            m_sym = 0; m_bit = 0; m_cmp = 0; m_meas = 1; m_hold = 0;
        end else if (m_meas && cmp) begin
            nbits = 0;
            for (int i = 0; i < 4; i++) if (m_so[i] != head[i]) nbits++;
            m_cmp++;
            if (nbits != 0) m_sym++;
            m_bit += nbits;
            if (m_cmp == WIN_LEN) begin
                m_meas = 0; m_hold = 1; m_done = 1;
            end
        end
        m_sv = rx_valid;
        if (rx_valid) m_so = {ref_code(int'(rx_I)), ref_code(int'(rx_Q))};
    endtask

    task automatic compare_all();
        chk("sym_valid", a_sym_valid, m_sv);
        chk("sym_out", a_sym_out, m_so);
        chk("sym_err", a_sym_err, sat(m_sym, CNT_W));
        chk("bit_err", a_bit_err, sat(m_bit, CNT_W));
        chk("cmp_cnt", a_cmp, m_cmp);
        chk("busy", a_busy, m_meas);
        chk("win_done", a_win_done, m_done);
        chk("ref_ovf", a_ovf, m_ovf);
        chk("ref_unf", a_unf, m_unf);
        chk("sat_sym_err", b_sym_err, sat(m_sym, CNT_W2));
        chk("sat_bit_err", b_bit_err, sat(m_bit, CNT_W2));
        chk("sat_cmp_cnt", b_cmp, m_cmp);
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        compare_all();
    endtask

    task automatic idle();
        rx_valid = 0; ref_valid = 0; start = 0;
    endtask

    task automatic pulse_start();
        start = 1; tick(); start = 0;
    endtask

    task automatic set_ref(input sym4_t s);
        ref_valid = 1;
        ref_I = sample_t'(amp(s[3:2]));
        ref_Q = sample_t'(amp(s[1:0]));
    endtask

    task automatic set_rx(input sym4_t s);
        rx_valid = 1;
        rx_I = noisy(amp(s[3:2]));
        rx_Q = noisy(amp(s[1:0]));
    endtask

    // Reference leads the received copy by 3 cycles; inv sends the bitwise complement symbol.
    task automatic run_pairs(input int n, input bit inv);
        sym4_t s;
        for (int c = 0; c < n + 3; c++) begin
            idle();
            if (c < n) set_ref(sym4_t'(c % 16));
            if (c >= 3) begin
                s = sym4_t'((c - 3) % 16);
                set_rx(inv ? ~s : s);
            end
            tick();
        end
        idle();
    endtask

    task automatic err_case(input string name, input int ri, input int rq,
                            input int xi, input int xq, input int w);
        pulse_start();
        ref_valid = 1; ref_I = sample_t'(ri); ref_Q = sample_t'(rq); tick();
        idle();
        rx_valid = 1; rx_I = sample_t'(xi); rx_Q = sample_t'(xq); tick();
        idle();
        tick(); tick();
        chk({name, "_sym"}, a_sym_err, 1);
        chk({name, "_bit"}, a_bit_err, w);
    endtask

    int          slc_v[8] = '{2047, 1296, 1295, 0, -1, -1296, -1297, -2048};
    logic [1:0]  slc_c[8] = '{2'b10, 2'b10, 2'b11, 2'b11, 2'b01, 2'b01, 2'b00, 2'b00};

    initial begin
        rst = 1; en = 1; idle();
        rx_I = '0; rx_Q = '0; ref_I = '0; ref_Q = '0;
        tick(); tick();
        chk("reset_busy", a_busy, 0);
        chk("reset_cmp", a_cmp, 0);
        chk("reset_sym_valid", a_sym_valid, 0);
        rst = 0;
        tick();

        // Matched full window.
        pulse_start();
        chk("start_busy", a_busy, 1);
        run_pairs(1024, 1'b0);
        tick();
        chk("bypass_win_done", a_win_done, 1);
        chk("bypass_cmp", a_cmp, 1024);
        chk("bypass_sym_err", a_sym_err, 0);
        chk("bypass_bit_err", a_bit_err, 0);
        chk("bypass_busy", a_busy, 0);
        tick();
        chk("bypass_single_pulse", a_win_done, 0);

        // Slicer thresholds on the I axis.
        for (int i = 0; i < 8; i++) begin
            rx_valid = 1; rx_I = sample_t'(slc_v[i]); rx_Q = '0;
            tick();
            chk($sformatf("slice_I_%0d", slc_v[i]), a_sym_out[3:2], slc_c[i]);
        end
        idle(); tick(); tick();

        err_case("err_w1", 1944, 1944, 648, 1943, 1);
        err_case("err_w2a", -1944, -1944, 648, -1943, 2);
        err_case("err_w2b", -1944, 1944, 1943, -1943, 2);

        // Overflow from IDLE, then compare the 16 retained references.
        rst = 1; tick(); rst = 0;
        for (int c = 0; c < 20; c++) begin
            idle(); set_ref(sym4_t'(c % 16)); tick();
        end
        idle(); tick();
        chk("ovf_set", a_ovf, 1);
        pulse_start();
        chk("ovf_cleared_by_start", a_ovf, 0);
        for (int c = 0; c < 16; c++) begin
            idle(); set_rx(sym4_t'(c % 16)); tick();
        end
        idle(); tick(); tick();
        chk("ovf_cmp", a_cmp, 16);
        chk("ovf_sym_err", a_sym_err, 0);
        chk("ovf_unf", a_unf, 0);

        // Underflow leaves counters untouched.
        rx_valid = 1; rx_I = 16'sd0; rx_Q = 16'sd0; tick();
        idle(); tick(); tick();
        chk("unf_set", a_unf, 1);
        chk("unf_cmp", a_cmp, 16);

        // Mid-window asynchronous reset.
        pulse_start();
        run_pairs(500, 1'b0);
        tick();
        chk("mid_cmp", a_cmp, 500);
        rst = 1;
        #1;
        chk("rst_busy", a_busy, 0);
        chk("rst_cmp", a_cmp, 0);
        chk("rst_sym_err", a_sym_err, 0);
        chk("rst_unf", a_unf, 0);
        tick();
        rst = 0;
        tick();
        pulse_start();
        run_pairs(1024, 1'b0);
        tick();
        chk("post_rst_cmp", a_cmp, 1024);
        chk("post_rst_done", a_win_done, 1);

        // Restart mid-window.
        pulse_start();
        run_pairs(300, 1'b0);
        tick();
        chk("restart_pre", a_cmp, 300);
        pulse_start();
        chk("restart_cmp", a_cmp, 0);
        chk("restart_busy", a_busy, 1);

        // Saturation of the narrow counters.
        tick(); tick();
        pulse_start();
        run_pairs(10, 1'b1);
        tick();
        chk("sat_bit_15", b_bit_err, 15);
        chk("sat_sym_10", b_sym_err, 10);
        chk("wide_bit_40", a_bit_err, 40);

        // Random traffic with enable gaps, restarts and occasional reset.
        for (int c = 0; c < 4000; c++) begin
            en        = ($urandom_range(0, 9) != 0);
            rst       = ($urandom_range(0, 1499) == 0);
            start     = ($urandom_range(0, 249) == 0);
            ref_valid = $urandom_range(0, 1);
            rx_valid  = $urandom_range(0, 1);
            ref_I     = sample_t'($urandom);
            ref_Q     = sample_t'($urandom);
            rx_I      = sample_t'($urandom);
            rx_Q      = sample_t'($urandom);
            tick();
        end
        rst = 0; en = 1; idle();
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
